// File: rtl/bsg_fpu_f2i_arbiter.sv
// Round-robin arbiter feeding one shared FP16-to-int16 converter through a 2-stage pipeline.
// Optional sticky invalid flag: define BSG_FPU_F2I_ARB_STICKY_EN.
module bsg_fpu_f2i_arbiter #(
  parameter int unsigned num_req_p   = 2,
  parameter int unsigned tag_width_p = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [num_req_p-1:0]               v_i,
  input  logic [16*num_req_p-1:0]            a_i,
  input  logic [num_req_p-1:0]               signed_i,
  input  logic [tag_width_p*num_req_p-1:0]   tag_i,
  output logic [num_req_p-1:0]               ready_o,
  output logic                               v_o,
  output logic [15:0]                        z_o,
  output logic                               invalid_o,
  output logic [$clog2(num_req_p)-1:0]       id_o,
  output logic [tag_width_p-1:0]             tag_o,
  input  logic                               yumi_i
`ifdef BSG_FPU_F2I_ARB_STICKY_EN
  ,
  input  logic                               clear_sticky_i,
  output logic                               sticky_invalid_o
`endif
);

  localparam int unsigned id_w = $clog2(num_req_p);

  logic                   s1_v;
  logic [15:0]            s1_a;
  logic                   s1_signed;
  logic [tag_width_p-1:0] s1_tag;
  logic [id_w-1:0]        s1_id;
  logic [id_w-1:0]        prio_q;

  logic                   move;
  logic                   s1_free;
  logic                   accept;
  logic                   found;
  logic [num_req_p-1:0]   grant;
  logic [id_w-1:0]        grant_id;

  // S1 advances whenever S2 is empty or being consumed this cycle.
  assign move    = s1_v & (~v_o | yumi_i);
  assign s1_free = ~s1_v | move;
  assign ready_o = (s1_free && reset_n_i) ? grant : '0;
  assign accept  = |ready_o;

  // Round-robin search starting at prio_q.
  always_comb begin : rr_pick
    int unsigned k;
    k        = 0;
    found    = 1'b0;
    grant    = '0;
    grant_id = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      k = 32'(prio_q) + i;
      if (k >= num_req_p) k = k - num_req_p;
      if (!found && v_i[id_w'(k)]) begin
        found               = 1'b1;
        grant[id_w'(k)]     = 1'b1;
        grant_id            = id_w'(k);
      end
    end
  end

  logic        cv_sgn;
  logic        cv_nan;
  logic [4:0]  cv_exp;
  logic [10:0] cv_sig;
  logic [31:0] cv_mag;
  logic [15:0] cv_z;
  logic        cv_inv;

  // Truncating converter; magnitude = {1,mant} scaled by exp-25.
  always_comb begin : conv
    cv_sgn = s1_a[15];
    cv_exp = s1_a[14:10];
    cv_sig = {1'b1, s1_a[9:0]};
    cv_nan = (s1_a[9:0] != 10'd0);
    cv_mag = '0;
    cv_z   = '0;
    cv_inv = 1'b0;
    if (cv_exp >= 5'd25)      cv_mag = 32'(cv_sig) << (cv_exp - 5'd25);
    else if (cv_exp >= 5'd15) cv_mag = 32'(cv_sig) >> (5'd25 - cv_exp);

    if (cv_exp == 5'd31) begin
      cv_inv = 1'b1;
      if (s1_signed) cv_z = (cv_sgn && !cv_nan) ? 16'h8000 : 16'h7fff;
      else           cv_z = (cv_sgn && !cv_nan) ? 16'h0000 : 16'hffff;
    end else if (s1_signed) begin
      if (!cv_sgn && cv_mag > 32'd32767) begin
        cv_z   = 16'h7fff;
        cv_inv = 1'b1;
      end else if (cv_sgn && cv_mag > 32'd32768) begin
        cv_z   = 16'h8000;
        cv_inv = 1'b1;
      end else begin
        cv_z = cv_sgn ? 16'(~cv_mag[15:0] + 16'd1) : cv_mag[15:0];
      end
    end else if (cv_sgn && cv_mag != 32'd0) begin
      cv_z   = 16'h0000;
      cv_inv = 1'b1;
    end else begin
      cv_z = cv_mag[15:0];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_v      <= 1'b0;
      s1_a      <= '0;
      s1_signed <= 1'b0;
      s1_tag    <= '0;
      s1_id     <= '0;
      prio_q    <= '0;
      v_o       <= 1'b0;
      z_o       <= '0;
      invalid_o <= 1'b0;
      id_o      <= '0;
      tag_o     <= '0;
    end else begin
      if (accept) begin
        s1_v      <= 1'b1;
        s1_a      <= a_i[32'(grant_id)*16 +: 16];
        s1_signed <= signed_i[grant_id];
        s1_tag    <= tag_i[32'(grant_id)*tag_width_p +: tag_width_p];
        s1_id     <= grant_id;
        prio_q    <= (grant_id == id_w'(num_req_p - 1)) ? '0 : grant_id + 1'b1;
      end else if (move) begin
        s1_v <= 1'b0;
      end

      if (move) begin
        v_o       <= 1'b1;
        z_o       <= cv_z;
        invalid_o <= cv_inv;
        id_o      <= s1_id;
        tag_o     <= s1_tag;
      end else if (yumi_i) begin
        v_o <= 1'b0;
      end
    end
  end

`ifdef BSG_FPU_F2I_ARB_STICKY_EN
  // Accumulates invalid results as they are consumed; clear has priority.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                        sticky_invalid_o <= 1'b0;
    else if (clear_sticky_i)               sticky_invalid_o <= 1'b0;
    else if (yumi_i && v_o && invalid_o)   sticky_invalid_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_bsg_fpu_f2i_arbiter.sv
// Bench for bsg_fpu_f2i_arbiter: capacity-2 queue model with real-valued conversion reference.
module tb_bsg_fpu_f2i_arbiter;
  localparam int NR = 2;
  localparam int TW = 4;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic [NR-1:0]     v_i;
  logic [16*NR-1:0]  a_i;
  logic [NR-1:0]     signed_i;
  logic [TW*NR-1:0]  tag_i;
  logic [NR-1:0]     ready_o;
  logic              v_o;
  logic [15:0]       z_o;
  logic              invalid_o;
  logic [0:0]        id_o;
  logic [TW-1:0]     tag_o;
  logic              yumi_i;
`ifdef BSG_FPU_F2I_ARB_STICKY_EN
  logic              clear_sticky_i;
  logic              sticky_invalid_o;
`endif

  bsg_fpu_f2i_arbiter #(.num_req_p(NR), .tag_width_p(TW)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .a_i       (a_i),
    .signed_i  (signed_i),
    .tag_i     (tag_i),
    .ready_o   (ready_o),
    .v_o       (v_o),
    .z_o       (z_o),
    .invalid_o (invalid_o),
    .id_o      (id_o),
    .tag_o     (tag_o),
    .yumi_i    (yumi_i)
`ifdef BSG_FPU_F2I_ARB_STICKY_EN
    ,
    .clear_sticky_i   (clear_sticky_i),
    .sticky_invalid_o (sticky_invalid_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0]   z;
    logic          inv;
    int            id;
    logic [TW-1:0] tag;
    int            age;
  } item_t;

  int            n_vec = 0;
  int            n_err = 0;
  item_t         q[$];
  int            prio;
  logic          pv[NR];
  logic [15:0]   pa[NR];
  logic          ps[NR];
  logic [TW-1:0] pt[NR];
  logic          want_yumi;
  logic          clr;
  logic          sticky_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference conversion via real arithmetic; returns {invalid, z}.
  function automatic logic [16:0] ref_conv(input logic [15:0] a, input logic sg);
    int   e;
    int   m;
    int   t;
    real  v;
    logic nan;
    e = int'(a[14:10]);
    m = int'(a[9:0]);
    if (e == 31) begin
      nan = (m != 0);
      if (sg) return {1'b1, (a[15] && !nan) ? 16'h8000 : 16'h7fff};
      return {1'b1, (a[15] && !nan) ? 16'h0000 : 16'hffff};
    end
    if (e == 0) v = real'(m) * 2.0 ** (-24);
    else        v = real'(1024 + m) * 2.0 ** (e - 25);
    if (a[15]) v = -v;
    t = $rtoi(v);
    if (sg) begin
      if (t > 32767)  return {1'b1, 16'h7fff};
      if (t < -32768) return {1'b1, 16'h8000};
      return {1'b0, 16'(t)};
    end
    if (t < 0) return {1'b1, 16'h0000};
    return {1'b0, 16'(t)};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 3))
      0:       r = r;
      1:       r[14:10] = 5'($urandom_range(13, 31));
      2:       r[14:10] = 5'($urandom_range(28, 31));
      default: r[14:10] = 5'($urandom_range(14, 18));
    endcase
    return r;
  endfunction

  function automatic logic busy();
    logic b;
    b = (q.size() != 0);
    for (int k = 0; k < NR; k++) b = b | pv[k];
    return b;
  endfunction

  task automatic put(input int k, input logic [15:0] a, input logic s, input logic [TW-1:0] t);
    pv[k] = 1'b1; pa[k] = a; ps[k] = s; pt[k] = t;
  endtask

  task automatic new_reqs(input int pct);
    for (int k = 0; k < NR; k++)
      if (!pv[k] && $urandom_range(0, 99) < pct)
        put(k, rand_op(), 1'($urandom), TW'($urandom));
  endtask

  // One cycle: drive at negedge, check, advance model on posedge.
  task automatic step();
    int          g;
    logic        vis;
    logic [16:0] r;
    for (int k = 0; k < NR; k++) begin
      v_i[k]           = pv[k];
      a_i[16*k +: 16]  = pa[k];
      signed_i[k]      = ps[k];
      tag_i[TW*k +: TW] = pt[k];
    end
    vis    = (q.size() > 0) && (q[0].age >= 2);
    yumi_i = want_yumi && vis;
`ifdef BSG_FPU_F2I_ARB_STICKY_EN
    clear_sticky_i = clr;
`endif
    #1;
    g = -1;
    if (q.size() < 2 || yumi_i)
      for (int i = 0; i < NR; i++)
        if (g < 0 && pv[(prio + i) % NR]) g = (prio + i) % NR;
    check("ready_o", 32'(ready_o), (g >= 0) ? (32'd1 << g) : 32'd0);
    check("v_o", 32'(v_o), 32'(vis));
    if (vis) begin
      check("z_o", 32'(z_o), 32'(q[0].z));
      check("invalid_o", 32'(invalid_o), 32'(q[0].inv));
      check("id_o", 32'(id_o), 32'(q[0].id));
      check("tag_o", 32'(tag_o), 32'(q[0].tag));
    end
`ifdef BSG_FPU_F2I_ARB_STICKY_EN
    check("sticky", 32'(sticky_invalid_o), 32'(sticky_m));
`endif
    @(posedge clk_i);
    if (clr) sticky_m = 1'b0;
    else if (yumi_i && q[0].inv) sticky_m = 1'b1;
    if (yumi_i) void'(q.pop_front());
    foreach (q[i]) q[i].age++;
    if (g >= 0) begin
      r = ref_conv(pa[g], ps[g]);
      q.push_back('{z: r[15:0], inv: r[16], id: g, tag: pt[g], age: 1});
      pv[g] = 1'b0;
      prio  = (g + 1) % NR;
    end
    @(negedge clk_i);
  endtask

  task automatic drain();
    want_yumi = 1'b1;
    clr       = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy()) break;
      step();
    end
    check("drain_timeout", 32'(busy()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(ready_o), 32'd0);
    check({tag, "_v"}, 32'(v_o), 32'd0);
    check({tag, "_z"}, 32'(z_o), 32'd0);
    check({tag, "_inv"}, 32'(invalid_o), 32'd0);
    check({tag, "_id"}, 32'(id_o), 32'd0);
    check({tag, "_tag"}, 32'(tag_o), 32'd0);
`ifdef BSG_FPU_F2I_ARB_STICKY_EN
    check({tag, "_sticky"}, 32'(sticky_invalid_o), 32'd0);
`endif
  endtask

  initial begin
    reset_n_i = 1'b1;
    v_i = '1; a_i = '0; signed_i = '0; tag_i = '0; yumi_i = 1'b0;
`ifdef BSG_FPU_F2I_ARB_STICKY_EN
    clear_sticky_i = 1'b0;
`endif
    clr = 1'b0; want_yumi = 1'b1; sticky_m = 1'b0; prio = 0;
    for (int k = 0; k < NR; k++) begin pv[k] = 1'b0; pa[k] = '0; ps[k] = 1'b0; pt[k] = '0; end
    #1 reset_n_i = 1'b0;
    #1 check_reset_outputs("rst0");
    @(negedge clk_i);
    reset_n_i = 1'b1;

    put(0, 16'h3c00, 1'b1, 4'd5);
    step();
    drain();
    put(1, 16'hc000, 1'b1, 4'd3);
    drain();
    put(1, 16'hc000, 1'b0, 4'd4);
    drain();
    put(0, 16'h7e00, 1'b1, 4'd7);
    drain();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();

    // Both requesting continuously: grants alternate, one result per cycle.
    for (int i = 0; i < 6; i++) begin
      new_reqs(100);
      step();
    end
    drain();

    // Consumer stall with both stages filling up.
    want_yumi = 1'b0;
    for (int i = 0; i < 6; i++) begin
      new_reqs(100);
      step();
    end
    drain();

    for (int i = 0; i < 600; i++) begin
      new_reqs(60);
      want_yumi = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 15) == 0);
      step();
    end
    drain();

    // Reset with both stages full.
    want_yumi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      new_reqs(100);
      step();
    end
    reset_n_i = 1'b0;
    #1 check_reset_outputs("rst_mid");
    q.delete();
    prio     = 0;
    sticky_m = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    want_yumi = 1'b1;
    new_reqs(100);
    step();
    drain();
    for (int i = 0; i < 100; i++) begin
      new_reqs(50);
      want_yumi = ($urandom_range(0, 2) != 0);
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
